wave_meas: RTL

- Measurement endpoint on the reading side of the signal chain.
- Consumes a signed sample stream (func_gen output or FIR_LPF dout) qualified by the f_s sampling strobe.
- Per cycle of the waveform, reports period (in samples), maximum, minimum and peak-to-peak amplitude, using hysteretic zero-crossing detection.
- Lets benches and on-chip monitors check filter passband/stopband behaviour without waveform inspection.

---
 rtl/wave_meas.sv | 120 ++++++++++++
 1 files changed

// File: rtl/wave_meas.sv
// Per-cycle waveform measurement of a sampled signed stream: period, max, min and
// peak-to-peak, framed by hysteretic rising zero crossings.
`timescale 1ns/1ps

module wave_meas #(
   parameter int DW         = 12,
   parameter int CW         = 16,
   parameter int HYST       = 16,
   parameter int MAX_PERIOD = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 f_s,
   input  logic signed [DW-1:0] din,
   output logic [CW-1:0]        period,
   output logic signed [DW-1:0] vmax,
   output logic signed [DW-1:0] vmin,
   output logic [DW:0]          p2p,
   output logic                 valid,
   output logic                 no_sig
);

   localparam logic signed [DW-1:0] HYST_POS = DW'(HYST);
   localparam logic signed [DW-1:0] HYST_NEG = -HYST_POS;
   localparam logic [CW-1:0]        MAX_CNT  = CW'(MAX_PERIOD);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic                 fs_s1, fs_s2, fs_d, samp_en;
   logic                 pol;
   logic [CW-1:0]        cnt;
   logic signed [DW-1:0] rmax, rmin;
   logic                 xing;
   logic [CW-1:0]        cnt_inc;
   logic [DW:0]          span;

   // f_s is foreign to clk: two flops to settle it, one more to find the rising edge,
   // and the enable itself is registered so the measurement logic sees a clean pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fs_s1   <= 1'b0;
         fs_s2   <= 1'b0;
         fs_d    <= 1'b0;
         samp_en <= 1'b0;
      end else begin
         fs_s1   <= f_s;
         fs_s2   <= fs_s1;
         fs_d    <= fs_s2;
         samp_en <= fs_s2 & ~fs_d;
      end
   end

   assign xing    = !pol && (din > HYST_POS);
   assign cnt_inc = cnt + CW'(1);
   assign span    = {rmax[DW-1], rmax} - {rmin[DW-1], rmin};

   // A timeout and a crossing on the same sample cannot both fire: the crossing branch wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pol    <= 1'b1;
         cnt    <= '0;
         rmax   <= '0;
         rmin   <= '0;
         period <= '0;
         vmax   <= '0;
         vmin   <= '0;
         p2p    <= '0;
         valid  <= 1'b0;
         no_sig <= 1'b1;
      end else begin
         valid <= 1'b0;
         if (samp_en) begin
            if (pol && (din < HYST_NEG)) begin
               pol <= 1'b0;
            end else if (xing) begin
               pol <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (xing) begin
                     state <= RUN;
                     cnt   <= '0;
                     rmax  <= din;
                     rmin  <= din;
                  end
               end
               RUN: begin
                  if (xing) begin
                     period <= cnt_inc;
                     vmax   <= rmax;
                     vmin   <= rmin;
                     p2p    <= span;
                     valid  <= 1'b1;
                     no_sig <= 1'b0;
                     cnt    <= '0;
                     rmax   <= din;
                     rmin   <= din;
                  end else begin
                     cnt  <= cnt_inc;
                     rmax <= (din > rmax) ? din : rmax;
                     rmin <= (din < rmin) ? din : rmin;
                     if (cnt_inc == MAX_CNT) begin
                        state  <= IDLE;
                        no_sig <= 1'b1;
                        period <= '0;
                        vmax   <= '0;
                        vmin   <= '0;
                        p2p    <= '0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
